// File: rtl/stage_collision_scanner.sv
// stage_collision_scanner
//   Sweeps a processor-loaded table of stage rectangles, one entry per clock,
//   against the player hitbox and publishes OR-accumulated contact flags in
//   the 5-bit `wall` format consumed by physics_coprocessor.
//
// Ports:
//   clock         master clock, all state updates on posedge
//   reset         asynchronous, active-high reset
//   position      {x[15:0], y[15:0]}, bottom-left corner of hitbox, y up
//   scan_start    single-cycle scan request (ignored unless idle)
//   drop_through  suppresses platform contact (bit 4) for the scan
//   wr_en         table write strobe
//   wr_addr       table entry index (out-of-range writes are dropped)
//   wr_data       {x0, x1, y0, y1}, inclusive bounds
//   wr_ctrl       {platform, enable}
//   wall          {platform_down, left, right, down, up}
//   wall_valid    one-cycle pulse when `wall` updates
//   busy          high while the table sweep is running
module stage_collision_scanner #(
    parameter int unsigned NUM_RECTS = 8,
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned PLAYER_W  = 16,
    parameter int unsigned PLAYER_H  = 24,
    parameter int unsigned MARGIN    = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       position,
    input  logic              scan_start,
    input  logic              drop_through,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [63:0]       wr_data,
    input  logic [1:0]        wr_ctrl,
    output logic [4:0]        wall,
    output logic              wall_valid,
    output logic              busy
);

    localparam int unsigned IDX_W = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RECTS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, PUBLISH} state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [15:0]       px;
    logic [15:0]       py;
    logic              drop_l;
    logic [4:0]        acc;

    logic [63:0]       rect_tab [NUM_RECTS];
    logic              en_tab   [NUM_RECTS];
    logic              plat_tab [NUM_RECTS];

    // Compare against the full-width address so aliasing into the table
    // cannot happen when ADDR_W is wider than the index.
    logic [31:0]       wr_addr_ext;
    logic              wr_hit;

    assign wr_addr_ext = 32'(wr_addr);
    assign wr_hit      = wr_en && (wr_addr_ext < NUM_RECTS);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_RECTS; i++) begin
                rect_tab[i] <= '0;
                en_tab[i]   <= 1'b0;
                plat_tab[i] <= 1'b0;
            end
        end else if (wr_hit) begin
            rect_tab[wr_addr[IDX_W-1:0]] <= wr_data;
            en_tab[wr_addr[IDX_W-1:0]]   <= wr_ctrl[0];
            plat_tab[wr_addr[IDX_W-1:0]] <= wr_ctrl[1];
        end
    end

    // Entry evaluation, 17-bit unsigned so edge sums never wrap. Lower
    // bounds are expressed as additions on the other side of the compare.
    logic [16:0] px17, py17, r17, t17, m17;
    logic [16:0] x0, x1, y0, y1;
    logic        entry_ok, ov_x, ov_y;
    logic        c_down, c_up, c_right, c_left;
    logic [4:0]  flags;

    always_comb begin
        px17 = {1'b0, px};
        py17 = {1'b0, py};
        r17  = px17 + 17'(PLAYER_W - 1);
        t17  = py17 + 17'(PLAYER_H - 1);
        m17  = 17'(MARGIN);
        x0   = {1'b0, rect_tab[idx][63:48]};
        x1   = {1'b0, rect_tab[idx][47:32]};
        y0   = {1'b0, rect_tab[idx][31:16]};
        y1   = {1'b0, rect_tab[idx][15:0]};

        entry_ok = en_tab[idx] && (x0 <= x1) && (y0 <= y1);
        ov_x     = (r17 >= x0) && (px17 <= x1);
        ov_y     = (t17 >= y0) && (py17 <= y1);
        c_down   = ov_x && (py17 >= y1) && (py17 <= y1 + m17);
        c_up     = ov_x && (t17 <= y0) && (t17 + m17 >= y0);
        c_right  = ov_y && (r17 <= x0) && (r17 + m17 >= x0);
        c_left   = ov_y && (px17 >= x1) && (px17 <= x1 + m17);

        flags = '0;
        if (entry_ok) begin
            if (plat_tab[idx])
                flags = {c_down && !drop_l, 4'b0000};
            else
                flags = {1'b0, c_left, c_right, c_down, c_up};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            px         <= '0;
            py         <= '0;
            drop_l     <= 1'b0;
            acc        <= '0;
            wall       <= '0;
            wall_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            wall_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (scan_start) begin
                        px     <= position[31:16];
                        py     <= position[15:0];
                        drop_l <= drop_through;
                        acc    <= '0;
                        idx    <= '0;
                        busy   <= 1'b1;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    acc <= acc | flags;
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        busy  <= 1'b0;
                        state <= PUBLISH;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                PUBLISH: begin
                    wall       <= acc;
                    wall_valid <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_collision_scanner.sv
// tb_stage_collision_scanner
//   Directed vectors with hand-computed contact vectors. The stimulus side
//   pushes the expected wall value and publish cycle into a scoreboard; a
//   monitor pops and compares on every wall_valid pulse. The DUT is built
//   with a 4-bit write address so out-of-range indices can be exercised.
module tb_stage_collision_scanner;

    localparam int unsigned NR = 8;

    logic        clock;
    logic        reset;
    logic [31:0] position;
    logic        scan_start;
    logic        drop_through;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [63:0] wr_data;
    logic [1:0]  wr_ctrl;
    logic [4:0]  wall;
    logic        wall_valid;
    logic        busy;

    stage_collision_scanner #(
        .NUM_RECTS (NR),
        .ADDR_W    (4),
        .PLAYER_W  (16),
        .PLAYER_H  (24),
        .MARGIN    (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .position     (position),
        .scan_start   (scan_start),
        .drop_through (drop_through),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ctrl      (wr_ctrl),
        .wall         (wall),
        .wall_valid   (wall_valid),
        .busy         (busy)
    );

    typedef struct {
        logic [4:0] wall;
        int         cyc;
        int         tag;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         tag_n = 0;
    logic [4:0] last_wall = '0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Monitor: every wall_valid pulse must match the oldest expectation,
    // both in value and in the cycle it appears.
    always @(negedge clock) begin
        if (!reset && wall_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: wall=%b at cycle %0d, expected no pulse", wall, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (wall !== e.wall || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL scan_%0d: wall=%b cycle=%0d, expected wall=%b cycle=%0d",
                             e.tag, wall, cyc, e.wall, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input int addr, input int x0, input int x1, input int y0, input int y1,
                      input logic [1:0] ctrl);
        @(posedge clock); #1;
        wr_en   = 1'b1;
        wr_addr = 4'(addr);
        wr_data = {16'(x0), 16'(x1), 16'(y0), 16'(y1)};
        wr_ctrl = ctrl;
        @(posedge clock); #1;
        wr_en   = 1'b0;
    endtask

    // One complete scan: wall must still hold the previous result, busy must
    // be high for exactly NR cycles, and the publish lands NR+1 edges after
    // the edge that samples scan_start.
    task automatic do_scan(input int x, input int y, input logic drop, input logic [4:0] exp);
        int busy_cnt;
        exp_t e;
        check("wall_hold", 32'(wall), 32'(last_wall));
        @(posedge clock); #1;
        position     = {16'(x), 16'(y)};
        drop_through = drop;
        scan_start   = 1'b1;
        tag_n++;
        e.wall = exp;
        e.cyc  = cyc + 1 + NR + 1;
        e.tag  = tag_n;
        sb.push_back(e);
        @(posedge clock); #1;
        scan_start = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < NR + 3; i++) begin
            @(negedge clock);
            if (busy) busy_cnt++;
        end
        check("busy_cycles", 32'(busy_cnt), 32'(NR));
        last_wall = exp;
    endtask

    initial begin
        reset        = 1'b1;
        position     = '0;
        scan_start   = 1'b0;
        drop_through = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        wr_ctrl      = '0;
        repeat (3) @(negedge clock);
        check("reset_wall", 32'(wall), 32'd0);
        check("reset_valid", 32'(wall_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // Floor contact
        wr(0, 0, 319, 0, 20, 2'b01);
        do_scan(100, 21, 1'b0, 5'b00010);

        // Platform and drop-through
        wr(1, 100, 200, 80, 84, 2'b11);
        do_scan(150, 85, 1'b0, 5'b10000);
        do_scan(150, 85, 1'b1, 5'b00000);

        // Side walls, including the exact margin boundaries
        wr(2, 300, 319, 0, 200, 2'b01);
        do_scan(284, 50, 1'b0, 5'b00100);
        do_scan(283, 50, 1'b0, 5'b00100);
        do_scan(282, 50, 1'b0, 5'b00000);
        do_scan(281, 50, 1'b0, 5'b00000);
        do_scan(320, 50, 1'b0, 5'b01000);
        do_scan(321, 50, 1'b0, 5'b01000);
        do_scan(322, 50, 1'b0, 5'b00000);

        // Ceiling and corner
        wr(3, 0, 319, 200, 220, 2'b01);
        do_scan(100, 176, 1'b0, 5'b00001);
        do_scan(284, 21, 1'b0, 5'b00110);

        // Extra starts at scan cycles 3, 8 and the publish cycle are dropped;
        // position/drop changes after the latch do not matter.
        begin
            exp_t e;
            check("wall_hold", 32'(wall), 32'(last_wall));
            @(posedge clock); #1;
            position     = {16'd284, 16'd21};
            drop_through = 1'b0;
            scan_start   = 1'b1;
            tag_n++;
            e.wall = 5'b00110;
            e.cyc  = cyc + 1 + NR + 1;
            e.tag  = tag_n;
            sb.push_back(e);
            for (int j = 0; j < 14; j++) begin
                @(posedge clock); #1;
                scan_start   = (j + 1 == 3) || (j + 1 == 8) || (j + 1 == 9);
                position     = {16'd320, 16'd50};
                drop_through = 1'b1;
            end
            scan_start = 1'b0;
            last_wall  = 5'b00110;
        end

        // Enable and malformed-entry handling
        wr(4, 30, 60, 0, 10, 2'b01);
        do_scan(38, 11, 1'b0, 5'b00010);
        wr(4, 30, 60, 0, 10, 2'b00);
        do_scan(38, 11, 1'b0, 5'b00000);
        wr(4, 50, 40, 0, 10, 2'b01);
        do_scan(38, 11, 1'b0, 5'b00000);
        wr(4, 30, 60, 10, 5, 2'b01);
        do_scan(38, 6, 1'b0, 5'b00000);
        wr(4, 0, 0, 0, 0, 2'b00);

        // Out-of-range address must not alias onto entry 1
        wr(9, 0, 0, 0, 0, 2'b00);
        do_scan(150, 85, 1'b0, 5'b10000);

        // Reset mid-scan: abort with no publish, table cleared
        @(posedge clock); #1;
        position     = {16'd150, 16'd85};
        drop_through = 1'b0;
        scan_start   = 1'b1;
        @(posedge clock); #1;
        scan_start = 1'b0;
        repeat (4) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("abort_wall", 32'(wall), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(wall_valid), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset     = 1'b0;
        last_wall = '0;
        repeat (12) @(posedge clock);
        do_scan(150, 85, 1'b0, 5'b00000);
        do_scan(284, 21, 1'b0, 5'b00000);
        do_scan(100, 21, 1'b0, 5'b00000);

        repeat (5) @(posedge clock);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage_collision_scanner.md
Name: stage_collision_scanner

Overview:
- Produces the 5-bit `wall` contact vector consumed by physics_coprocessor.
- Takes that block's 32-bit `position` output: x in [31:16], y in [15:0], y increasing upward.
- Compares the player hitbox against a processor-loaded table of stage rectangles, one rectangle per clock.
- Publishes the OR-accumulated contact flags once per scan, with a one-cycle valid pulse.

Parameters:
- NUM_RECTS, 8, number of rectangle table entries.
- ADDR_W, 3, table address width; must satisfy 2^ADDR_W >= NUM_RECTS.
- PLAYER_W, 16, hitbox width in pixels.
- PLAYER_H, 24, hitbox height in pixels.
- MARGIN, 2, contact tolerance in pixels.

Ports:
- clock  in  1  master clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- position  in  32  player position {x[15:0], y[15:0]}, unsigned; (x,y) is the bottom-left corner of the hitbox.
- scan_start  in  1  single-cycle request to begin a scan.
- drop_through  in  1  when high, platform contact (bit 4) is suppressed for this scan.
- wr_en  in  1  table write strobe.
- wr_addr  in  ADDR_W  table entry index.
- wr_data  in  64  rectangle {x0[63:48], x1[47:32], y0[31:16], y1[15:0]}, inclusive bounds.
- wr_ctrl  in  2  {platform, enable}.
- wall  out  5  {platform_down, left, right, down, up} = bits [4:0].
- wall_valid  out  1  one-cycle pulse when `wall` updates.
- busy  out  1  high while a scan is in progress.

Behaviour:
- Reset (async) clears:
  - all table entries to enable=0;
  - wall=0, wall_valid=0, busy=0;
  - FSM to IDLE, scan index to 0.
- A reset asserted mid-scan aborts the scan; no partial result is ever published.
- FSM states: IDLE, SCAN, PUBLISH.
- IDLE:
  - On scan_start=1, latch position into px/py and latch drop_through.
  - Clear the accumulator, set idx=0, go to SCAN, busy=1.
- SCAN:
  - Evaluate entry[idx] each cycle and OR its flags into the accumulator.
  - idx increments each cycle; after idx=NUM_RECTS-1, go to PUBLISH.
- PUBLISH:
  - wall <= accumulator, wall_valid=1 for exactly this cycle.
  - busy=0, return to IDLE.
- Latency: scan_start sampled at edge 0 → wall/wall_valid valid after edge NUM_RECTS+1.
- scan_start while busy=1 is ignored; it is not queued.
- scan_start in the PUBLISH cycle is also ignored. Minimum scan period is NUM_RECTS+2 cycles.
- `wall` holds its value between publishes.
- All arithmetic is 17-bit unsigned (zero-extended) so edge sums never wrap:
  - R = px+PLAYER_W-1, T = py+PLAYER_H-1.
- Entry evaluation:
  - ovX = (R >= x0) & (px <= x1); ovY = (T >= y0) & (py <= y1).
  - down: ovX & (py >= y1) & (py <= y1+MARGIN).
  - up: ovX & (T <= y0) & (T+MARGIN >= y0).
  - right: ovY & (R <= x0) & (R+MARGIN >= x0).
  - left: ovY & (px >= x1) & (px <= x1+MARGIN).
  - Lower-bound subtractions are done as additions on the other side, so there is no underflow at 0.
- Solid entry (platform=0) contributes up/down/left/right.
- Platform entry (platform=1):
  - contributes only bit 4, using the down condition;
  - bit 4 is forced to 0 if the latched drop_through=1.
- Entries with enable=0, x0>x1, or y0>y1 contribute nothing.
- Table writes:
  - Take effect at the next edge and are legal at any time.
  - A write during SCAN is seen only if it lands before that entry's evaluation cycle.
  - A write to the entry being evaluated in the same cycle is not seen; the old value is used.
  - wr_addr >= NUM_RECTS is ignored.
- position changes after the latch do not affect the current scan.

Test Plan:
- Floor contact:
  - Stimulus: entry0 = {0,319,0,20}, ctrl=01; position=(100,21); scan_start.
  - Response: after 9 edges wall=5'b00010, wall_valid one cycle; busy high for exactly 8 cycles.
- Platform and drop-through:
  - Stimulus: entry1 = {100,200,80,84}, ctrl=11; position=(150,85).
  - Response: wall=5'b10000; repeating with drop_through=1 gives wall=5'b00000.
- Side walls:
  - Stimulus: entry2 = {300,319,0,200} solid.
  - Response: position=(284,50) → wall=5'b00100; position=(320,50) → wall=5'b01000; position=(281,50) → 0.
- Ceiling and corner:
  - Stimulus: entry3 = {0,319,200,220} solid; position=(100,176) → wall=5'b00001.
  - Stimulus: add entry0 floor and entry2, position=(284,21).
  - Response: wall=5'b00110 (OR of multiple entries).
- Control and protocol:
  - scan_start pulsed at cycles 3 and 8 after the first start → ignored; only one wall_valid pulse.
  - Disabled entry or malformed entry {50,40,0,10} → no flags.
  - wr_addr=9 with NUM_RECTS=8 → no effect.
- Reset mid-scan:
  - Stimulus: assert reset asynchronously at scan cycle 4.
  - Response: wall=0, busy=0, wall_valid never pulses; after release all entries are disabled and a new scan returns 0.
